// File: rtl/axil_master_seq.sv
// AXI4-Lite initiator: turns single-beat read/write commands into AW/W/B or AR/R
// handshakes and returns the captured data and response on a result port.
module axil_master_seq #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int RESP_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      m3_axi_aclk,
   input  logic                      m3_axi_areset,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [RESP_WIDTH-1:0]     rsp_resp,

   output logic [ADDR_WIDTH-1:0]     m3_axi_awaddr,
   output logic                      m3_axi_awvalid,
   input  logic                      m3_axi_awready,
   output logic [DATA_WIDTH-1:0]     m3_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m3_axi_wstrb,
   output logic                      m3_axi_wvalid,
   input  logic                      m3_axi_wready,
   input  logic [RESP_WIDTH-1:0]     m3_axi_bresp,
   input  logic                      m3_axi_bvalid,
   output logic                      m3_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m3_axi_araddr,
   output logic                      m3_axi_arvalid,
   input  logic                      m3_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m3_axi_rdata,
   input  logic [RESP_WIDTH-1:0]     m3_axi_rresp,
   input  logic                      m3_axi_rvalid,
   output logic                      m3_axi_rready,

   output logic [2:0]                dbg_state
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);
   localparam int WD_WIDTH   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK    = ~ADDR_WIDTH'((1 << LSB) - 1);
   localparam logic [WD_WIDTH-1:0]   WD_LIMIT     = WD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [RESP_WIDTH-1:0] RESP_TIMEOUT = RESP_WIDTH'(4);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;
   logic                    write_q;
   logic                    aw_done, w_done;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [RESP_WIDTH-1:0]   resp_q;
   logic [WD_WIDTH-1:0]     wd_cnt;
   logic                    busy, timeout;
   logic                    cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
   logic                    unused_resp_hi;

   // Every channel transfers on the rising edge where valid and ready are both
   // high; valids here come from registered state only and never look at a ready.
   assign busy    = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_DATA);
   assign timeout = (TIMEOUT_CYCLES != 0) && busy && (wd_cnt == WD_LIMIT);

   assign cmd_ready      = (state == IDLE);
   assign rsp_valid      = (state == DONE);
   assign m3_axi_awvalid = (state == WR_REQ)  && !aw_done && !timeout;
   assign m3_axi_wvalid  = (state == WR_REQ)  && !w_done  && !timeout;
   assign m3_axi_bready  = (state == WR_RESP) && !timeout;
   assign m3_axi_arvalid = (state == RD_REQ)  && !timeout;
   assign m3_axi_rready  = (state == RD_DATA) && !timeout;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign aw_fire  = m3_axi_awvalid && m3_axi_awready;
   assign w_fire   = m3_axi_wvalid  && m3_axi_wready;
   assign b_fire   = m3_axi_bvalid  && m3_axi_bready;
   assign ar_fire  = m3_axi_arvalid && m3_axi_arready;
   assign r_fire   = m3_axi_rvalid  && m3_axi_rready;

   assign m3_axi_awaddr = addr_q;
   assign m3_axi_araddr = addr_q;
   assign m3_axi_wdata  = wdata_q;
   assign m3_axi_wstrb  = wstrb_q;
   assign rsp_write     = write_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign dbg_state     = state;

   // Upper response bits from the slave are not forwarded; bit 2 is ours.
   assign unused_resp_hi = &{1'b0, m3_axi_bresp[RESP_WIDTH-1:2], m3_axi_rresp[RESP_WIDTH-1:2]};

   always_ff @(posedge m3_axi_aclk or posedge m3_axi_areset) begin
      if (m3_axi_areset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (timeout) begin
         state_next = DONE;
      end else begin
         case (state)
            IDLE:    if (cmd_fire) state_next = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
            WR_RESP: if (b_fire) state_next = DONE;
            RD_REQ:  if (ar_fire) state_next = RD_DATA;
            RD_DATA: if (r_fire) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge m3_axi_aclk or posedge m3_axi_areset) begin
      if (m3_axi_areset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         write_q <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= '0;
         resp_q  <= '0;
         wd_cnt  <= '0;
      end else begin
         if (cmd_fire) begin
            addr_q  <= cmd_addr & ADDR_MASK;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
         end
         if (aw_fire) aw_done <= 1'b1;
         if (w_fire)  w_done  <= 1'b1;
         if (b_fire)  resp_q  <= RESP_WIDTH'(m3_axi_bresp[1:0]);
         if (r_fire) begin
            rdata_q <= m3_axi_rdata;
            resp_q  <= RESP_WIDTH'(m3_axi_rresp[1:0]);
         end
         if (timeout) begin
            rdata_q <= '0;
            resp_q  <= RESP_TIMEOUT;
         end
         // Watchdog measures time spent in the current phase only.
         if (state_next != state) begin
            wd_cnt <= '0;
         end else if (busy && (TIMEOUT_CYCLES != 0)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axil_master_seq.sv
// Bench for axil_master_seq: AXI-Lite slave model with per-channel wait states,
// directed commands, and a response scoreboard fed by the command driver.
module tb_axil_master_seq;

   localparam logic [7:0]  T2_ADDR  [3] = '{8'h10, 8'h13, 8'h18};
   localparam logic [7:0]  T2_EADDR [3] = '{8'h10, 8'h10, 8'h18};
   localparam logic [31:0] T2_DATA  [3] = '{32'h0000_0055, 32'hA5A5_A5A5, 32'h0BAD_0000};
   localparam logic [3:0]  T2_STRB  [3] = '{4'hF, 4'h3, 4'hC};
   localparam logic [2:0]  T2_BRESP [3] = '{3'd0, 3'd0, 3'd2};
   localparam int T2_AWD [3] = '{3, 1, 0};
   localparam int T2_WD  [3] = '{0, 1, 2};
   localparam int T2_BD  [3] = '{0, 0, 2};
   localparam int T2_AWC [3] = '{4, 2, 1};
   localparam int T2_WC  [3] = '{1, 2, 3};
   localparam int T2_BF  [3] = '{5, 3, 4};
   localparam int T2_BC  [3] = '{1, 1, 3};
   localparam int T2_RSP [3] = '{6, 4, 7};

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [2:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  bresp, rresp, dbg_state;

   logic [35:0] exp_q[$];
   logic [31:0] mem [0:63];
   int n_total, n_pass, n_sent, n_rsp;
   int aw_delay, w_delay, b_delay, r_delay;
   bit ar_block;
   logic [2:0] b_resp_cfg, r_resp_cfg;

   bit tracking;
   int cyc, aw_first, aw_cnt, w_first, w_cnt, b_first, b_cnt;
   int ar_first, ar_cnt, r_first, r_cnt, rsp_first;
   logic [7:0]  aw_addr_seen, ar_addr_seen;
   logic [31:0] wdata_seen;
   logic [3:0]  wstrb_seen;

   axil_master_seq #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .m3_axi_aclk(clk), .m3_axi_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m3_axi_awaddr(awaddr), .m3_axi_awvalid(awvalid), .m3_axi_awready(awready),
      .m3_axi_wdata(wdata), .m3_axi_wstrb(wstrb), .m3_axi_wvalid(wvalid), .m3_axi_wready(wready),
      .m3_axi_bresp(bresp), .m3_axi_bvalid(bvalid), .m3_axi_bready(bready),
      .m3_axi_araddr(araddr), .m3_axi_arvalid(arvalid), .m3_axi_arready(arready),
      .m3_axi_rdata(rdata), .m3_axi_rresp(rresp), .m3_axi_rvalid(rvalid), .m3_axi_rready(rready),
      .dbg_state(dbg_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1, "bench timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Slave model: readies and response valids change only on the falling edge.
   initial begin : aw_slave
      int n;
      n = 0; awready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin awready = 1'b0; n = 0; end
         else if (awready) awready = 1'b0;
         else if (awvalid) begin
            if (n >= aw_delay) begin awready = 1'b1; n = 0; end else n++;
         end else n = 0;
      end
   end

   initial begin : w_slave
      int n;
      n = 0; wready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin wready = 1'b0; n = 0; end
         else if (wready) wready = 1'b0;
         else if (wvalid) begin
            if (n >= w_delay) begin wready = 1'b1; n = 0; end else n++;
         end else n = 0;
      end
   end

   initial begin : b_slave
      int n;
      n = 0; bvalid = 1'b0; bresp = 3'd0;
      forever begin
         @(negedge clk);
         if (rst) begin bvalid = 1'b0; n = 0; end
         else if (bvalid) bvalid = 1'b0;
         else if (bready) begin
            if (n >= b_delay) begin
               bvalid = 1'b1; bresp = b_resp_cfg; n = 0;
               for (int k = 0; k < 4; k++)
                  if (wstrb[k]) mem[awaddr[7:2]][k*8 +: 8] = wdata[k*8 +: 8];
            end else n++;
         end
      end
   end

   initial begin : ar_slave
      arready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) arready = 1'b0;
         else if (arready) arready = 1'b0;
         else if (arvalid && !ar_block) arready = 1'b1;
      end
   end

   initial begin : r_slave
      int n;
      n = 0; rvalid = 1'b0; rdata = '0; rresp = 3'd0;
      forever begin
         @(negedge clk);
         if (rst) begin rvalid = 1'b0; n = 0; end
         else if (rvalid) rvalid = 1'b0;
         else if (rready) begin
            if (n >= r_delay) begin
               rvalid = 1'b1; rdata = mem[araddr[7:2]]; rresp = r_resp_cfg; n = 0;
            end else n++;
         end
      end
   end

   // Per-command timing recorder; cycle 1 is the first cycle after the accept edge.
   initial begin : timing_mon
      tracking = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) tracking = 1'b0;
         else begin
            if (tracking) begin
               cyc++;
               if (awvalid) begin
                  if (aw_cnt == 0) begin aw_first = cyc; aw_addr_seen = awaddr; end
                  aw_cnt++;
               end
               if (wvalid) begin
                  if (w_cnt == 0) begin w_first = cyc; wdata_seen = wdata; wstrb_seen = wstrb; end
                  w_cnt++;
               end
               if (bready) begin if (b_cnt == 0) b_first = cyc; b_cnt++; end
               if (arvalid) begin
                  if (ar_cnt == 0) begin ar_first = cyc; ar_addr_seen = araddr; end
                  ar_cnt++;
               end
               if (rready) begin if (r_cnt == 0) r_first = cyc; r_cnt++; end
               if (rsp_valid && rsp_first == 0) rsp_first = cyc;
            end
            if (cmd_valid && cmd_ready) begin
               tracking = 1'b1; cyc = 0;
               aw_first = 0; aw_cnt = 0; w_first = 0; w_cnt = 0; b_first = 0; b_cnt = 0;
               ar_first = 0; ar_cnt = 0; r_first = 0; r_cnt = 0; rsp_first = 0;
            end
         end
      end
   end

   // Scoreboard: pops one expected response per result handshake.
   initial begin : sb_mon
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL rsp_unexpected: got 0x%0h with empty queue, expected no response",
                        {rsp_write, rsp_rdata, rsp_resp});
            end else begin
               e = exp_q.pop_front();
               check("rsp", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'(e));
            end
            n_rsp++;
         end
      end
   end

   task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [35:0] e, input bit push,
                       input bit hold, output int waited);
      int n;
      if (push) begin exp_q.push_back(e); n_sent++; end
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
         if (n > 100) begin
            n_total++;
            $display("FAIL cmd_accept: cmd_ready low for %0d cycles, expected high", n);
            break;
         end
      end
      waited = n;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n;
      n = 0;
      while (n_rsp < target && n < 300) begin @(negedge clk); n++; end
      if (n_rsp < target) begin
         n_total++;
         $display("FAIL wait_rsp: got %0d responses, expected %0d", n_rsp, target);
      end
      @(posedge clk); #1;
   endtask

   initial begin : main
      int waited, n;
      n_total = 0; n_pass = 0; n_sent = 0; n_rsp = 0;
      aw_delay = 0; w_delay = 0; b_delay = 0; r_delay = 0; ar_block = 1'b0;
      b_resp_cfg = 3'd0; r_resp_cfg = 3'd0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[2] = 32'hDEAD_BEEF;

      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
      check("rst_rsp", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'd0);
      check("rst_bus", 64'({awaddr, araddr, wdata, wstrb}), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write, zero-wait slave
      send(1'b1, 8'h04, 32'd34, 4'hF, {1'b1, 32'd0, 3'd0}, 1'b1, 1'b0, waited);
      wait_rsp(n_sent);
      check("t1_aw_first", 64'(aw_first), 64'd1);
      check("t1_w_first", 64'(w_first), 64'd1);
      check("t1_awaddr", 64'(aw_addr_seen), 64'h04);
      check("t1_wdata", 64'(wdata_seen), 64'd34);
      check("t1_b_first", 64'(b_first), 64'd2);
      check("t1_b_cnt", 64'(b_cnt), 64'd1);
      check("t1_rsp_first", 64'(rsp_first), 64'd3);
      check("t1_no_read", 64'(ar_cnt + r_cnt), 64'd0);

      // Writes with skewed AW/W readies and B wait states
      for (int i = 0; i < 3; i++) begin
         aw_delay = T2_AWD[i]; w_delay = T2_WD[i]; b_delay = T2_BD[i]; b_resp_cfg = T2_BRESP[i];
         send(1'b1, T2_ADDR[i], T2_DATA[i], T2_STRB[i], {1'b1, 32'd0, T2_BRESP[i]},
              1'b1, 1'b0, waited);
         wait_rsp(n_sent);
         check($sformatf("t2_%0d_aw_cnt", i), 64'(aw_cnt), 64'(T2_AWC[i]));
         check($sformatf("t2_%0d_w_cnt", i), 64'(w_cnt), 64'(T2_WC[i]));
         check($sformatf("t2_%0d_b_first", i), 64'(b_first), 64'(T2_BF[i]));
         check($sformatf("t2_%0d_b_cnt", i), 64'(b_cnt), 64'(T2_BC[i]));
         check($sformatf("t2_%0d_rsp_first", i), 64'(rsp_first), 64'(T2_RSP[i]));
         check($sformatf("t2_%0d_awaddr", i), 64'(aw_addr_seen), 64'(T2_EADDR[i]));
         check($sformatf("t2_%0d_wstrb", i), 64'({wdata_seen, wstrb_seen}), 64'({T2_DATA[i], T2_STRB[i]}));
      end
      aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 3'd0;

      // Read with slow R channel and result back-pressure
      rsp_ready = 1'b0; r_delay = 5; r_resp_cfg = 3'd2;
      send(1'b0, 8'h08, 32'd0, 4'h0, {1'b0, 32'hDEAD_BEEF, 3'd2}, 1'b1, 1'b0, waited);
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("t3_hold%0d_rdata", i), 64'(rsp_rdata), 64'hDEAD_BEEF);
         check($sformatf("t3_hold%0d_resp", i), 64'({rsp_valid, rsp_resp}), 64'({1'b1, 3'd2}));
         check($sformatf("t3_hold%0d_cmd_ready", i), 64'(cmd_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t3_cmd_ready_at_hs", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      check("t3_cmd_ready_after", 64'({cmd_ready, rsp_valid}), 64'({1'b1, 1'b0}));
      check("t3_ar", 64'({ar_first, ar_cnt}), 64'({32'd1, 32'd1}));
      check("t3_araddr", 64'(ar_addr_seen), 64'h08);
      check("t3_r", 64'({r_first, r_cnt}), 64'({32'd2, 32'd6}));
      check("t3_rsp_first", 64'(rsp_first), 64'd8);
      wait_rsp(n_sent);
      r_delay = 0; r_resp_cfg = 3'd0;

      // Back-to-back write then read with cmd_valid held through the busy period
      send(1'b1, 8'h00, 32'd25, 4'hF, {1'b1, 32'd0, 3'd0}, 1'b1, 1'b1, waited);
      check("t6_wr_wait", 64'(waited), 64'd0);
      send(1'b0, 8'h00, 32'hFFFF_FFFF, 4'hF, {1'b0, 32'd25, 3'd0}, 1'b1, 1'b0, waited);
      check("t6_rd_wait", 64'(waited), 64'd2);
      wait_rsp(n_sent);
      check("t6_rd_rsp_first", 64'(rsp_first), 64'd3);
      check("t6_rd_araddr", 64'(ar_addr_seen), 64'h00);

      // Async reset while AW is outstanding
      aw_delay = 20;
      send(1'b1, 8'h20, 32'h77, 4'hF, 36'd0, 1'b0, 1'b0, waited);
      #2;
      check("t5_pre_valids", 64'({awvalid, wvalid}), 64'({1'b1, 1'b1}));
      rst = 1'b1;
      #1;
      check("t5_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
      check("t5_rst_idle", 64'({cmd_ready, dbg_state}), 64'({1'b1, 3'd0}));
      check("t5_rst_awaddr", 64'(awaddr), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; aw_delay = 0;
      check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
      send(1'b0, 8'h04, 32'd0, 4'h0, {1'b0, 32'd34, 3'd0}, 1'b1, 1'b0, waited);
      wait_rsp(n_sent);
      check("t5_rd_rsp_first", 64'(rsp_first), 64'd3);
      check("t5_rd_r_first", 64'(r_first), 64'd2);

      // Watchdog: AR never accepted
      ar_block = 1'b1;
      send(1'b0, 8'h0C, 32'd0, 4'h0, {1'b0, 32'd0, 3'b100}, 1'b1, 1'b0, waited);
      wait_rsp(n_sent);
      check("t4_ar_cnt", 64'(ar_cnt), 64'd16);
      check("t4_rsp_first", 64'(rsp_first), 64'd18);
      check("t4_no_rready", 64'(r_cnt), 64'd0);
      ar_block = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axil_master_seq.md
Name: axil_master_seq

Overview:
- AXI4-Lite initiator: the bus-master counterpart to the team's s3_axi_* register-slave wrapper.
- Takes single-beat read/write commands on a simple valid/ready command port and runs the AXI-Lite handshakes (AW/W/B or AR/R).
- Returns data and response on a result port.
- Replaces hand-driven bench stimulus and serves as the on-chip master for register-bank access.

Parameters:
DATA_WIDTH  32  data bus width; strobe width is DATA_WIDTH/8
ADDR_WIDTH  8  byte address width
RESP_WIDTH  3  response width; bits[1:0] carry AXI resp, bit[2] is the local timeout flag
TIMEOUT_CYCLES  256  max wait cycles per AXI phase; 0 disables the watchdog

Ports:
m3_axi_aclk  in  1  clock, all logic on rising edge
m3_axi_areset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted on valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  result present
rsp_ready  in  1  result consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  RESP_WIDTH  captured bresp/rresp, or timeout code
m3_axi_awaddr  out  ADDR_WIDTH;  m3_axi_awvalid  out  1;  m3_axi_awready  in  1
m3_axi_wdata  out  DATA_WIDTH;  m3_axi_wstrb  out  DATA_WIDTH/8;  m3_axi_wvalid  out  1;  m3_axi_wready  in  1
m3_axi_bresp  in  RESP_WIDTH;  m3_axi_bvalid  in  1;  m3_axi_bready  out  1
m3_axi_araddr  out  ADDR_WIDTH;  m3_axi_arvalid  out  1;  m3_axi_arready  in  1
m3_axi_rdata  in  DATA_WIDTH;  m3_axi_rresp  in  RESP_WIDTH;  m3_axi_rvalid  in  1;  m3_axi_rready  out  1

Behaviour:
- **Reset** (async, immediate, also mid-transaction):
  - state=IDLE; cmd_ready=1.
  - All AXI valid/ready outputs, rsp_valid, rsp_write, rsp_rdata, rsp_resp, addr/data/strb outputs = 0.
  - Any in-flight transaction is dropped.
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: capture addr (low log2(DATA_WIDTH/8) bits forced to 0), wdata, wstrb, write flag.
  - Go to WR_REQ or RD_REQ; cmd_ready=0 from the next cycle.
- **WR_REQ:**
  - awvalid=wvalid=1 from the cycle after accept.
  - aw_done/w_done flags track each handshake independently: AW first, W first, or both in the same cycle are all legal.
  - Each valid drops the cycle after its own handshake.
  - When both done: WR_RESP.
- **WR_RESP:** bready=1; on bvalid&bready capture bresp, bready=0, go to DONE.
- **RD_REQ:** arvalid=1 until arready; then RD_DATA.
- **RD_DATA:** rready=1; on rvalid&rready capture rdata and rresp, rready=0, go to DONE.
- **DONE:**
  - rsp_valid=1; results held stable until rsp_ready.
  - Then IDLE, with cmd_ready=1 the following cycle.
  - For writes, rsp_rdata=0.
- **Stability and ignored inputs:**
  - AXI address/data/strb are stable while the matching valid is high.
  - Command inputs are ignored outside IDLE.
  - No valid output ever depends combinationally on a ready input.
- **Latency (zero-wait slave, cycle 0 = accept edge):**
  - Write: aw/wvalid in cycle 1; bready in cycle 2; rsp_valid in cycle 3 if bvalid is seen in cycle 2.
  - Read: arvalid in cycle 1; rready in cycle 2; rsp_valid in cycle 3.
- **Watchdog:**
  - Counter cleared on every state change; increments each cycle spent in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - On reaching TIMEOUT_CYCLES: all AXI valid/ready outputs forced to 0; go to DONE with rsp_resp=3'b100 and rsp_rdata=0.
  - Debug-only abort; bus state after an abort is undefined, and a reset is required before further traffic.
  - TIMEOUT_CYCLES=0 disables the counter.
- **Response codes:** rsp_resp[1:0] are passed through unmodified (OKAY/EXOKAY/SLVERR/DECERR); no retries.

Test Plan:
- **Write, zero-wait slave:** write addr=0x04, data=34, strb=0xF → awaddr=0x04, wdata=34 in cycle 1; one bready pulse; rsp_valid in cycle 3 with rsp_resp=0, rsp_write=1.
- **Write with skewed readies:** awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid holds 4 cycles, bready only after both handshakes; a same-cycle AW/W handshake case also passes.
- **Read with back-pressure:** read addr=0x08, slave returns rdata=0xDEADBEEF, rresp=2 after 5-cycle rvalid delay; rsp_ready held low 3 cycles → rsp_rdata/rsp_resp stable; cmd_ready=1 only after the rsp handshake.
- **Timeout:** TIMEOUT_CYCLES=16, slave never asserts arready → arvalid drops after 16 cycles; rsp_valid with rsp_resp=3'b100, rsp_rdata=0.
- **Async reset mid-write:** assert m3_axi_areset while awvalid=1 → all valids and rsp_valid drop before the next clock edge; after release, cmd_ready=1 and a new read completes normally.
- **Back-to-back:** write 25 to addr 0, then read addr 0 from a memory model → rsp_rdata=25; cmd_valid held high during busy is ignored until IDLE.
